// File: rtl/rram_ctrl_pkg.sv
// Shared types for the RRAM column sequencer: command opcodes, bitline
// level codes, FSM states and the pulse-counter width helper.
package rram_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR    = 2'd0,
        OP_PROGRAM  = 2'd1,
        OP_FORWARD  = 2'd2,
        OP_BACKPROP = 2'd3
    } op_e;

    // Code 3 is reserved and never driven onto the bitline.
    typedef enum logic [1:0] {
        BL_ZERO = 2'd0,
        BL_BACK = 2'd1,
        BL_SET  = 2'd2
    } bl_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_PRE,
        ST_SET,
        ST_POST,
        ST_SETTLE,
        ST_BPRE,
        ST_BACK,
        ST_BPOST
    } state_e;

    // Enough bits to hold the longest SET pulse (max weight * UNIT_CYC).
    function automatic int pulse_cnt_w(input int wgt_w, input int unit_cyc);
        return $clog2((2 ** wgt_w - 1) * unit_cyc + 1);
    endfunction

endpackage

// File: rtl/rram_col_ctrl_if.sv
// Command port between the training scheduler and the column sequencer.
interface rram_col_ctrl_if #(
    parameter int ROWS  = 8,
    parameter int WGT_W = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_op;
    logic [$clog2(ROWS)-1:0]  cmd_row;
    logic [WGT_W-1:0]         cmd_weight;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_weight,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_weight,
        output cmd_ready
    );
endinterface

// File: rtl/rram_pulse_timer.sv
// Down-counter shared by all timed phases. start loads the phase length on
// entry; expire is high on the last cycle of the phase (count == 1).
module rram_pulse_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] load,
    output logic             expire
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load on start, otherwise count down and park at zero (no wrap).
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = load;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/rram_col_ctrl.sv
// Sequencer for one RRAM crossbar column: wordline hold mask, bitline level
// and strobes for CLEAR / PROGRAM / FORWARD / BACKPROP.
// Optional: define RRAM_COL_CTRL_PERF_EN to add saturating event counters.
module rram_col_ctrl
    import rram_ctrl_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int WGT_W      = 4,
    parameter int UNIT_CYC   = 10,
    parameter int SETTLE_CYC = 4,
    parameter int BACK_CYC   = 2,
    parameter int RST_CYC    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    rram_col_ctrl_if.slave    cmd,
    output logic [ROWS-1:0]   wl,
    output logic [1:0]        bl_lvl,
    output logic              dback,
    output logic              rd_sample,
    output logic              done,
    output logic              err
`ifdef RRAM_COL_CTRL_PERF_EN
    ,
    output logic [15:0]       perf_prog,
    output logic [15:0]       perf_back,
    output logic [15:0]       perf_rej
`endif
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = pulse_cnt_w(WGT_W, UNIT_CYC);

    state_e            state_q, state_d;
    logic [ROWS-1:0]   hold_q, hold_d;
    logic [WGT_W-1:0]  wgt_q, wgt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              tmr_start, tmr_expire;
    logic [CNT_W-1:0]  tmr_load;
    logic [ROWS-1:0]   row_onehot;
    logic              row_oob, accept;
    bl_e               bl;
    op_e               op;

    assign op         = op_e'(cmd.cmd_op);
    assign row_onehot = {{(ROWS-1){1'b0}}, 1'b1} << cmd.cmd_row;
    assign row_oob    = ({1'b0, cmd.cmd_row} >= (ROW_W+1)'(ROWS));
    // Hold off a new command while the registered done of CLEAR/FORWARD shows.
    assign cmd.cmd_ready = (state_q == ST_IDLE) && !done_q;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    rram_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (tmr_start),
        .load   (tmr_load),
        .expire (tmr_expire)
    );

    // Next-state, hold-mask update and per-state analog outputs.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wgt_d     = wgt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmr_start = 1'b0;
        tmr_load  = '0;
        wl        = hold_q;
        bl        = BL_ZERO;
        dback     = 1'b0;
        rd_sample = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_CLEAR: begin
                            hold_d    = '0;
                            state_d   = ST_CLR;
                            tmr_start = 1'b1;
                            tmr_load  = CNT_W'(RST_CYC);
                        end
                        OP_PROGRAM: begin
                            if (row_oob || ((hold_q & ~row_onehot) != '0)) begin
                                err_d = 1'b1;
                            end else begin
                                // Raise the wordline already in PRE so the cell is held.
                                hold_d  = hold_q | row_onehot;
                                wgt_d   = cmd.cmd_weight;
                                state_d = ST_PRE;
                            end
                        end
                        OP_FORWARD: begin
                            if (hold_q == '0) begin
                                err_d = 1'b1;
                            end else begin
                                state_d   = ST_SETTLE;
                                tmr_start = 1'b1;
                                tmr_load  = CNT_W'(SETTLE_CYC);
                            end
                        end
                        OP_BACKPROP: begin
                            if (hold_q == '0) err_d   = 1'b1;
                            else              state_d = ST_BPRE;
                        end
                    endcase
                end
            end
            ST_CLR: begin
                wl = '0;
                if (tmr_expire) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_PRE: begin
                if (wgt_q == '0) begin
                    state_d = ST_POST;
                end else begin
                    state_d   = ST_SET;
                    tmr_start = 1'b1;
                    tmr_load  = CNT_W'(wgt_q) * CNT_W'(UNIT_CYC);
                end
            end
            ST_SET: begin
                bl = BL_SET;
                if (tmr_expire) state_d = ST_POST;
            end
            ST_POST: begin
                state_d = ST_IDLE;
            end
            ST_SETTLE: begin
                if (tmr_expire) begin
                    rd_sample = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_BPRE: begin
                dback     = 1'b1;
                state_d   = ST_BACK;
                tmr_start = 1'b1;
                tmr_load  = CNT_W'(BACK_CYC);
            end
            ST_BACK: begin
                dback = 1'b1;
                bl    = BL_BACK;
                if (tmr_expire) state_d = ST_BPOST;
            end
            ST_BPOST: begin
                dback   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bl_lvl = bl;
    assign done   = done_q || (state_q == ST_POST) || (state_q == ST_BPOST);
    assign err    = err_q;

    // State, hold mask and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            wgt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wgt_q   <= wgt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef RRAM_COL_CTRL_PERF_EN
    logic [15:0] perf_prog_q, perf_prog_d;
    logic [15:0] perf_back_q, perf_back_d;
    logic [15:0] perf_rej_q,  perf_rej_d;

    // Saturating event counters; only rst_n clears them.
    always_comb begin
        perf_prog_d = perf_prog_q;
        perf_back_d = perf_back_q;
        perf_rej_d  = perf_rej_q;
        if ((state_q == ST_POST) && (perf_prog_q != 16'hFFFF))  perf_prog_d = perf_prog_q + 16'd1;
        if ((state_q == ST_BPOST) && (perf_back_q != 16'hFFFF)) perf_back_d = perf_back_q + 16'd1;
        if (err_d && (perf_rej_q != 16'hFFFF))                  perf_rej_d  = perf_rej_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_prog_q <= '0;
            perf_back_q <= '0;
            perf_rej_q  <= '0;
        end else begin
            perf_prog_q <= perf_prog_d;
            perf_back_q <= perf_back_d;
            perf_rej_q  <= perf_rej_d;
        end
    end

    assign perf_prog = perf_prog_q;
    assign perf_back = perf_back_q;
    assign perf_rej  = perf_rej_q;
`endif
endmodule

// File: tb/tb_rram_col_ctrl.sv
// Directed bench for rram_col_ctrl; outputs sampled on the falling edge.
module tb_rram_col_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wl;
    logic [1:0] bl_lvl;
    logic       dback, rd_sample, done, err;
`ifdef RRAM_COL_CTRL_PERF_EN
    logic [15:0] perf_prog, perf_back, perf_rej;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int viol   = 0;
    logic [1:0] bl_prev = 2'd0;

    always #5 clk = ~clk;

    rram_col_ctrl_if #(.ROWS(8), .WGT_W(4)) cif ();

    rram_col_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cif),
        .wl        (wl),
        .bl_lvl    (bl_lvl),
        .dback     (dback),
        .rd_sample (rd_sample),
        .done      (done),
        .err       (err)
`ifdef RRAM_COL_CTRL_PERF_EN
        ,
        .perf_prog (perf_prog),
        .perf_back (perf_back),
        .perf_rej  (perf_rej)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a command at the first idle falling edge; returns on the falling
    // edge right after the accepting rising edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] row, input logic [3:0] wgt);
        int k = 0;
        @(negedge clk);
        while (!cif.cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!cif.cmd_ready) check("issue_ready_timeout", 32'd0, 32'd1);
        cif.cmd_valid  = 1'b1;
        cif.cmd_op     = op;
        cif.cmd_row    = row;
        cif.cmd_weight = wgt;
        @(negedge clk);
        cif.cmd_valid  = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    // Invariants on every active cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bl_lvl == 2'd3) viol++;
            if (dback && bl_lvl == 2'd2) viol++;
            if (done && err) viol++;
            if ((bl_prev == 2'd1 && bl_lvl == 2'd2) || (bl_prev == 2'd2 && bl_lvl == 2'd1)) viol++;
            bl_prev = bl_lvl;
        end else begin
            bl_prev = 2'd0;
        end
    end

    initial begin
        int set_cnt, last_set, done_at, rd_at, db_cnt;
        logic [9:0] seq;

        rst_n = 1'b0;
        cif.cmd_valid = 1'b0; cif.cmd_op = 2'd0; cif.cmd_row = 3'd0; cif.cmd_weight = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_wl", wl, 0);
        check("rst_bl", bl_lvl, 0);
        check("rst_dback", dback, 0);
        check("rst_rd_done_err", {rd_sample, done, err}, 0);
        check("rst_ready", cif.cmd_ready, 1);
        rst_n = 1'b1;

        // 1: PROGRAM row2 w=3 -> 30 SET cycles, done right after.
        issue(2'd1, 3'd2, 4'd3);
        check("p1_pre_wl", wl, 8'h04);
        check("p1_pre_bl", bl_lvl, 0);
        check("p1_pre_ready", cif.cmd_ready, 0);
        set_cnt = 0; last_set = -1; done_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bl_lvl == 2'd2) begin set_cnt++; last_set = i; end
            if (done && done_at < 0) done_at = i;
        end
        check("p1_set_cycles", set_cnt, 30);
        check("p1_done_at", done_at, 31);
        check("p1_done_after_fall", done_at - last_set, 1);
        check("p1_wl_held", wl, 8'h04);
        check("p1_ready", cif.cmd_ready, 1);

        // 2: PROGRAM row2 w=0 -> SET skipped, done 2 cycles after accept.
        issue(2'd1, 3'd2, 4'd0);
        set_cnt = 0; done_at = -1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (bl_lvl == 2'd2) set_cnt++;
            if (done && done_at < 0) done_at = i + 1;
        end
        check("p2_no_set", set_cnt, 0);
        check("p2_done_lat", done_at, 2);
        check("p2_wl", wl, 8'h04);

        // 3: conflicting PROGRAM rejected; then CLEAR.
        issue(2'd1, 3'd5, 4'd1);
        check("p3_err", err, 1);
        check("p3_wl", wl, 8'h04);
        check("p3_ready", cif.cmd_ready, 1);
        check("p3_no_done", done, 0);
        @(negedge clk);
        check("p3_err_pulse", err, 0);
        issue(2'd0, 3'd0, 4'd0);
        check("clr_wl0", wl, 0);
        check("clr_done0", done, 0);
        @(negedge clk);
        check("clr_wl1", wl, 0);
        check("clr_done1", done, 0);
        @(negedge clk);
        check("clr_done", done, 1);
        @(negedge clk);
        check("clr_done_pulse", done, 0);
        check("clr_ready", cif.cmd_ready, 1);

        // 4: FORWARD with empty hold rejected; after PROGRAM, FORWARD samples.
        issue(2'd2, 3'd0, 4'd0);
        check("f_rej_err", err, 1);
        issue(2'd1, 3'd1, 4'd1);
        wait_done();
        issue(2'd2, 3'd0, 4'd0);
        rd_at = -1; done_at = -1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) check("fwd_wl", wl, 8'h02);
            if (rd_sample && rd_at < 0) rd_at = i;
            if (done && done_at < 0) done_at = i;
        end
        check("fwd_rd_sample_at", rd_at, 3);
        check("fwd_done_at", done_at, 4);

        // 5: BACKPROP -> bl 0,1,1,0 with dback high for 4 cycles.
        issue(2'd3, 3'd0, 4'd0);
        seq = '0; db_cnt = 0; done_at = -1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            seq = {seq[7:0], bl_lvl};
            if (dback) db_cnt++;
            if (bl_lvl == 2'd1 && !dback) db_cnt = 99;
            if (done && done_at < 0) done_at = i;
        end
        check("bp_bl_seq", seq, 10'b00_01_01_00_00);
        check("bp_dback_cycles", db_cnt, 4);
        check("bp_done_at", done_at, 3);
        check("bp_wl", wl, 8'h02);

`ifdef RRAM_COL_CTRL_PERF_EN
        check("perf_prog", perf_prog, 3);
        check("perf_back", perf_back, 1);
        check("perf_rej", perf_rej, 2);
`endif

        // 6: async reset in the middle of a SET pulse.
        issue(2'd1, 3'd1, 4'd15);
        repeat (5) @(negedge clk);
        check("r6_in_set", bl_lvl, 2);
        #2 rst_n = 1'b0;
        #1;
        check("r6_bl_async", bl_lvl, 0);
        check("r6_wl_async", wl, 0);
        check("r6_dback_async", dback, 0);
`ifdef RRAM_COL_CTRL_PERF_EN
        check("r6_perf_clr", {perf_prog, perf_back}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("r6_ready", cif.cmd_ready, 1);
        check("r6_bl_idle", bl_lvl, 0);

        check("invariants", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
